// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a qualification FSM that accepts a new level
// only after STABLE_CYCLES consecutive synchronised samples, counting aborted attempts.
module input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din,
  input  logic                glitch_clr,
  output logic                dout,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_CHECK_HIGH,
    ST_HIGH,
    ST_CHECK_LOW
  } state_t;

  logic                s1_q, s2_q;
  logic                din_s;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GLITCH_W-1:0] gc_q, gc_d;
  logic                glitch;

  assign din_s = s2_q;

  // The first sample at the new level is consumed in the stable state, so CHECK
  // starts at cnt=1 and accepts on CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    glitch  = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (din_s) begin
          state_d = ST_CHECK_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_CHECK_HIGH: begin
        if (!din_s) begin
          state_d = ST_LOW;
          glitch  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!din_s) begin
          state_d = ST_CHECK_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_CHECK_LOW: begin
        if (din_s) begin
          state_d = ST_HIGH;
          glitch  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  // Clear takes priority over a simultaneous glitch; count saturates at all-ones.
  always_comb begin
    gc_d = gc_q;
    if (glitch_clr) begin
      gc_d = '0;
    end else if (glitch && (gc_q != '1)) begin
      gc_d = gc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ST_LOW;
      cnt_q   <= '0;
      gc_q    <= '0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gc_q    <= gc_d;
    end
  end

  assign dout         = (state_q == ST_HIGH) || (state_q == ST_CHECK_LOW);
  assign busy         = (state_q == ST_CHECK_HIGH) || (state_q == ST_CHECK_LOW);
  assign glitch_count = gc_q;

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Upstream conditioning stage for the edge detector. Synchronises a raw asynchronous input (button, strap, external strobe) into the `clk` domain and filters out bounce and short glitches. It presents a clean, stable level on `dout`, which drives the edge detector's `din` directly. It also keeps a saturating count of rejected glitches for debug.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronised samples at the new level required before `dout` changes. Legal range is ≥ 2.
- `GLITCH_W`, default 8: width of `glitch_count`.

- `clk`  in  1: single clock; all logic is posedge.
- `reset`  in  1: synchronous, active-high reset.
- `din`  in  1: raw input, asynchronous to `clk`.
- `glitch_clr`  in  1: synchronous clear of `glitch_count`.
- `dout`  out  1: debounced level.
- `busy`  out  1: high while a candidate transition is being qualified.
- `glitch_count`  out  GLITCH_W: number of aborted transitions, saturating.

## Operation
- **Synchroniser:** two flops, `din` → `s1` → `s2`; `din_s` = `s2`. Nothing else samples `din`.
- **State machine:** states LOW, CHECK_HIGH, HIGH, CHECK_LOW. Qualification counter `cnt` is $clog2(STABLE_CYCLES) bits wide.
  - LOW, `din_s`=1: go to CHECK_HIGH, `cnt`←1.
  - LOW, `din_s`=0: stay in LOW.
  - CHECK_HIGH, `din_s`=0: return to LOW; glitch event.
  - CHECK_HIGH, `din_s`=1, `cnt`==STABLE_CYCLES-1: go to HIGH.
  - CHECK_HIGH, `din_s`=1, otherwise: `cnt`++.
  - HIGH and CHECK_LOW mirror LOW and CHECK_HIGH with `din_s` inverted:
    - HIGH, `din_s`=0: go to CHECK_LOW, `cnt`←1.
    - CHECK_LOW, `din_s`=1: return to HIGH; glitch event.
    - CHECK_LOW, `din_s`=0, `cnt`==STABLE_CYCLES-1: go to LOW.
    - CHECK_LOW, `din_s`=0, otherwise: `cnt`++.
- **Outputs, decoded from the state register (no extra flop):**
  - `dout` = state ∈ {HIGH, CHECK_LOW}.
  - `busy` = state ∈ {CHECK_HIGH, CHECK_LOW}.
- **Glitch counter:**
  - +1 on each glitch event.
  - Holds at all-ones; never wraps.
  - `glitch_clr` forces it to 0. If a clear and a glitch event occur on the same edge, the clear wins and the result is 0.
- **Reset:** `s1`, `s2`, `cnt` and `glitch_count` all go to 0, and the state goes to LOW.
  - Resulting outputs: `dout`=0, `busy`=0, `glitch_count`=0.
  - Reset asserted mid-qualification or in HIGH still returns to LOW. No partial `cnt` is retained.
- **Exact qualification:** a level is accepted when exactly STABLE_CYCLES consecutive `din_s` samples are at the new level.
  - The first of those samples is taken in LOW/HIGH; the remaining STABLE_CYCLES-1 are taken in the CHECK state.
  - A single opposite sample aborts the qualification and restarts it from the stable state.

## Timing
- Edge numbering: edge 1 is the first posedge at which `din` is already at its new level.
  - Edge 1: `s1` updates.
  - Edge 2: `s2` updates.
  - Edge 3: the state enters CHECK_*.
  - Edge STABLE_CYCLES+2: `dout` changes.
- Latency for a clean transition is STABLE_CYCLES+2 cycles; with the default this is 6.
- Minimum accepted pulse width is STABLE_CYCLES cycles of `din` (before synchroniser uncertainty). Shorter pulses never reach `dout`.
- `busy` rises at edge 3 and falls on the same edge that `dout` changes or that the glitch is counted.
- `glitch_count` updates on the edge that the CHECK→stable abort occurs.
- `din` constant for ≥ 2 edges after reset deasserts gives `din_s` equal to `din`. Output `dout` then follows the rules above, starting from LOW.
- Downstream edge detector: each `dout` 0→1 produces exactly one rising event there, so bounce must never produce more than one `dout` transition.

## Test plan
- **Reset:** hold `reset`=1 for 3 cycles with `din`=1.
  - Required: `dout`=0, `busy`=0, `glitch_count`=0 throughout reset.
  - After release, `dout` rises at edge 6.
- **Clean rise and fall** (STABLE_CYCLES=4):
  - `din` 0→1 held: `dout`=1 after edge 6, `busy` high from edge 3 to edge 6.
  - `din` 1→0 held: `dout`=0 after 6 edges.
  - `glitch_count` stays 0.
- **Glitch rejection:**
  - `din` high for 2 cycles then low: `dout` stays 0, `glitch_count`=1.
  - `din` high for exactly 3 cycles: also rejected, `glitch_count`=2.
  - `din` high for 4 cycles: `dout` goes 1 and later returns to 0 via qualification.
- **Bounce burst:** `din` toggles 1,0,1,1,0,1 (one cycle each), then holds 1.
  - Required: exactly one `dout` 0→1 transition, 6 edges after the final stable 1 begins.
  - `glitch_count` increments once per abort.
- **Saturation and clear** (GLITCH_W=2):
  - Generate 5 glitches: `glitch_count` reaches 3 and holds at 3.
  - `glitch_clr` pulsed on the same edge as a glitch abort: result 0.
- **Reset mid-operation:** assert `reset` while in CHECK_HIGH with `cnt`=2, while `din` stays 1.
  - Required: LOW on the next edge.
  - Full 6-edge latency after release; no early `dout` rise.
